// File: rtl/uart_axi_pkg.sv
// Shared types and helpers for the uart_axi controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package uart_axi_pkg;

  typedef enum logic [1:0] {
    CMD_WR = 2'd0,
    CMD_RD = 2'd1,
    CMD_RB = 2'd2
  } cmd_op_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SYNTAX  = 2'd1,
    ERR_LENGTH  = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_t;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_SP = 8'h20;

  // Returns {valid, nibble}; accepts 0-9, a-f and A-F.
  function automatic logic [4:0] hex2nib(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      // Letter codes end in 1..6, so adding 9 yields 10..15.
      r = {1'b1, b[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// ASCII line parser: turns "w AAAA DDDDDDDD", "r AAAA", "br AAAA LL" lines into decoded commands.
// Latency: command valid the cycle after the terminating CR; error strobe the cycle after the bad byte.
// Backpressure: command held until i_cmd_ready; RX cannot stall, so bytes arriving while holding are dropped with ERR_OVERRUN.
module uart_cmd_parser
  import uart_axi_pkg::*;
#(
  parameter int P_ADDR_W = 16,
  parameter int P_DATA_W = 32,
  parameter int P_LEN_W  = 8
) (
  input  logic                aclk,
  input  logic                rst,
  input  logic                i_rx_valid,
  input  logic [7:0]          i_rx_data,
  output logic                o_cmd_valid,
  input  logic                i_cmd_ready,
  output logic [1:0]          o_cmd_op,
  output logic [P_ADDR_W-1:0] o_cmd_addr,
  output logic [P_DATA_W-1:0] o_cmd_wdata,
  output logic [P_LEN_W-1:0]  o_cmd_len,
  output logic                o_err_valid,
  output logic [1:0]          o_err_code,
  output logic                o_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_OPB, S_SP1, S_ADDR, S_SP2, S_DATA, S_LEN, S_CR, S_ISSUE, S_FLUSH
  } state_t;

  // Digit counter value on the final digit of each field.
  localparam logic [3:0] ADDR_LAST = 4'(P_ADDR_W / 4 - 1);
  localparam logic [3:0] DATA_LAST = 4'(P_DATA_W / 4 - 1);
  localparam logic [3:0] LEN_LAST  = 4'(P_LEN_W / 4 - 1);

  state_t                state_q, state_d;
  cmd_op_t               op_q, op_d;
  logic [P_ADDR_W-1:0]   addr_q;
  logic [P_DATA_W-1:0]   data_q;
  logic [P_LEN_W-1:0]    len_q;
  logic [3:0]            cnt_q;
  logic                  err_vld_q;
  err_code_t             err_code_q, err_code_d;
  logic                  err_set, shift_addr, shift_data, shift_len, cnt_inc, cnt_clr;

  logic [4:0] hx;
  logic       is_hex;
  logic [3:0] nib;
  logic [7:0] lc;
  logic       is_cr;

  assign hx     = hex2nib(i_rx_data);
  assign is_hex = hx[4];
  assign nib    = hx[3:0];
  assign lc     = i_rx_data | 8'h20;  // folds command letters to lower case
  assign is_cr  = (i_rx_data == CHR_CR);

  // State register.
  always_ff @(posedge aclk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and per-byte actions.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    shift_len  = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    err_set    = 1'b0;
    err_code_d = ERR_NONE;
    if (state_q == S_ISSUE) begin
      if (i_cmd_ready) state_d = S_IDLE;
      if (i_rx_valid) begin
        err_set    = 1'b1;
        err_code_d = ERR_OVERRUN;
      end
    end else if (i_rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (lc == 8'h77) begin
            op_d = CMD_WR; state_d = S_SP1;
          end else if (lc == 8'h72) begin
            op_d = CMD_RD; state_d = S_SP1;
          end else if (lc == 8'h62) begin
            op_d = CMD_RB; state_d = S_OPB;
          end else if (!is_cr && i_rx_data != CHR_LF) begin
            err_set = 1'b1; err_code_d = ERR_SYNTAX; state_d = S_FLUSH;
          end
        end
        S_OPB: begin
          if (lc == 8'h72) begin
            state_d = S_SP1;
          end else begin
            // A CR here already ends the line, so there is nothing to flush.
            err_set = 1'b1; err_code_d = ERR_SYNTAX;
            state_d = is_cr ? S_IDLE : S_FLUSH;
          end
        end
        S_SP1, S_SP2: begin
          if (i_rx_data == CHR_SP) begin
            if (state_q == S_SP1)     state_d = S_ADDR;
            else if (op_q == CMD_WR)  state_d = S_DATA;
            else                      state_d = S_LEN;
          end else if (is_cr) begin
            err_set = 1'b1; err_code_d = ERR_LENGTH; state_d = S_IDLE;
          end else begin
            err_set = 1'b1; err_code_d = ERR_SYNTAX; state_d = S_FLUSH;
          end
        end
        S_ADDR, S_DATA, S_LEN: begin
          if (is_hex) begin
            shift_addr = (state_q == S_ADDR);
            shift_data = (state_q == S_DATA);
            shift_len  = (state_q == S_LEN);
            if (state_q == S_ADDR && cnt_q == ADDR_LAST) begin
              cnt_clr = 1'b1;
              state_d = (op_q == CMD_RD) ? S_CR : S_SP2;
            end else if ((state_q == S_DATA && cnt_q == DATA_LAST) ||
                         (state_q == S_LEN  && cnt_q == LEN_LAST)) begin
              cnt_clr = 1'b1;
              state_d = S_CR;
            end else begin
              cnt_inc = 1'b1;
            end
          end else if (is_cr) begin
            err_set = 1'b1; err_code_d = ERR_LENGTH; state_d = S_IDLE;
          end else begin
            err_set = 1'b1; err_code_d = ERR_SYNTAX; state_d = S_FLUSH;
          end
        end
        S_CR: begin
          if (is_cr) begin
            state_d = S_ISSUE;
          end else begin
            err_set    = 1'b1;
            err_code_d = is_hex ? ERR_LENGTH : ERR_SYNTAX;
            state_d    = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (is_cr) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Field accumulators, opcode and digit counter; wiped whenever the parser returns to idle.
  always_ff @(posedge aclk) begin
    if (rst || state_d == S_IDLE) begin
      op_q   <= CMD_WR;
      addr_q <= '0;
      data_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      op_q <= op_d;
      if (shift_addr) addr_q <= {addr_q[P_ADDR_W-5:0], nib};
      if (shift_data) data_q <= {data_q[P_DATA_W-5:0], nib};
      if (shift_len)  len_q  <= {len_q[P_LEN_W-5:0], nib};
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 4'd1;
    end
  end

  // One-cycle registered error strobe.
  always_ff @(posedge aclk) begin
    if (rst) begin
      err_vld_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      err_vld_q  <= err_set;
      err_code_q <= err_set ? err_code_d : ERR_NONE;
    end
  end

  assign o_cmd_valid = (state_q == S_ISSUE);
  assign o_cmd_op    = op_q;
  assign o_cmd_addr  = addr_q;
  assign o_cmd_wdata = data_q;
  assign o_cmd_len   = len_q;
  assign o_err_valid = err_vld_q;
  assign o_err_code  = err_code_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: one task per scenario with hand-computed expectations.
module tb_uart_cmd_parser;

  logic        aclk = 1'b0;
  logic        rst;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic [1:0]  o_cmd_op;
  logic [15:0] o_cmd_addr;
  logic [31:0] o_cmd_wdata;
  logic [7:0]  o_cmd_len;
  logic        o_err_valid;
  logic [1:0]  o_err_code;
  logic        o_busy;

  int checks = 0;
  int fails  = 0;
  int err_seen = 0;

  uart_cmd_parser dut (
    .aclk(aclk), .rst(rst),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_op(o_cmd_op), .o_cmd_addr(o_cmd_addr), .o_cmd_wdata(o_cmd_wdata), .o_cmd_len(o_cmd_len),
    .o_err_valid(o_err_valid), .o_err_code(o_err_code), .o_busy(o_busy)
  );

  always #5 aclk = ~aclk;

  // Counts every cycle the error strobe is high, so a stuck strobe shows up as extra events.
  always @(negedge aclk) if (o_err_valid === 1'b1) err_seen++;

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1; i_rx_data = b;
    tick();
    i_rx_valid = 1'b0; i_rx_data = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (o_cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", o_cmd_valid); end
    checks++; if (o_err_valid !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", o_err_valid); end
    checks++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if ({o_cmd_op, o_cmd_addr, o_cmd_wdata, o_cmd_len, o_err_code} !== 60'd0) begin fails++; $display("FAIL reset_fields op=%0h addr=%h wdata=%h len=%h code=%0h exp=all 0", o_cmd_op, o_cmd_addr, o_cmd_wdata, o_cmd_len, o_err_code); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int e0 = err_seen;
    send_str("w 0FEC 1234ABCD");
    checks++; if (o_cmd_valid !== 1'b0 || o_busy !== 1'b1) begin fails++; $display("FAIL wr_pre_cr valid=%b busy=%b exp valid=0 busy=1", o_cmd_valid, o_busy); end
    send_byte(8'h0D);
    checks++; if (o_cmd_valid !== 1'b1) begin fails++; $display("FAIL wr_valid got=%b exp=1", o_cmd_valid); end
    checks++; if (o_cmd_op !== 2'd0) begin fails++; $display("FAIL wr_op got=%0d exp=0", o_cmd_op); end
    checks++; if (o_cmd_addr !== 16'h0FEC) begin fails++; $display("FAIL wr_addr got=%h exp=0fec", o_cmd_addr); end
    checks++; if (o_cmd_wdata !== 32'h1234ABCD) begin fails++; $display("FAIL wr_wdata got=%h exp=1234abcd", o_cmd_wdata); end
    checks++; if (o_cmd_len !== 8'h00) begin fails++; $display("FAIL wr_len got=%h exp=00", o_cmd_len); end
    i_cmd_ready = 1'b1; tick(); i_cmd_ready = 1'b0;
    checks++; if (o_cmd_valid !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL wr_after_hs valid=%b busy=%b exp 0 0", o_cmd_valid, o_busy); end
    checks++; if (err_seen !== e0) begin fails++; $display("FAIL wr_no_err strobes=%0d exp=0", err_seen - e0); end
  endtask

  task automatic test_read_stall();
    send_str("r 0fec"); send_byte(8'h0D);
    for (int i = 0; i < 20; i++) begin
      checks++; if (o_cmd_valid !== 1'b1 || o_cmd_op !== 2'd1 || o_cmd_addr !== 16'h0FEC || o_cmd_wdata !== 32'd0) begin fails++; $display("FAIL rd_stall cyc=%0d valid=%b op=%0d addr=%h wdata=%h exp 1/1/0fec/0", i, o_cmd_valid, o_cmd_op, o_cmd_addr, o_cmd_wdata); end
      tick();
    end
    i_cmd_ready = 1'b1; tick(); i_cmd_ready = 1'b0;
    checks++; if (o_cmd_valid !== 1'b0) begin fails++; $display("FAIL rd_drop got=%b exp=0", o_cmd_valid); end
  endtask

  task automatic test_burst();
    send_str("br 0000 03"); send_byte(8'h0D);
    checks++; if (o_cmd_valid !== 1'b1 || o_cmd_op !== 2'd2) begin fails++; $display("FAIL rb_valid_op valid=%b op=%0d exp 1/2", o_cmd_valid, o_cmd_op); end
    checks++; if (o_cmd_addr !== 16'h0000 || o_cmd_len !== 8'h03 || o_cmd_wdata !== 32'd0) begin fails++; $display("FAIL rb_fields addr=%h len=%h wdata=%h exp 0000/03/0", o_cmd_addr, o_cmd_len, o_cmd_wdata); end
    i_cmd_ready = 1'b1; tick(); i_cmd_ready = 1'b0;
  endtask

  task automatic test_syntax();
    int e0 = err_seen;
    send_str("w 00g");
    checks++; if (o_err_valid !== 1'b1 || o_err_code !== 2'd1) begin fails++; $display("FAIL syn_strobe valid=%b code=%0d exp 1/1", o_err_valid, o_err_code); end
    send_str("4 00000000"); send_byte(8'h0D);
    checks++; if (o_cmd_valid !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL syn_flush valid=%b busy=%b exp 0/0", o_cmd_valid, o_busy); end
    checks++; if (err_seen !== e0 + 1) begin fails++; $display("FAIL syn_count strobes=%0d exp=1", err_seen - e0); end
    send_str("r 0004"); send_byte(8'h0D);
    checks++; if (o_cmd_valid !== 1'b1 || o_cmd_op !== 2'd1 || o_cmd_addr !== 16'h0004 || o_cmd_wdata !== 32'd0) begin fails++; $display("FAIL syn_recover valid=%b op=%0d addr=%h wdata=%h exp 1/1/0004/0", o_cmd_valid, o_cmd_op, o_cmd_addr, o_cmd_wdata); end
    i_cmd_ready = 1'b1; tick(); i_cmd_ready = 1'b0;
  endtask

  task automatic test_length();
    int e0 = err_seen;
    send_str("r 004"); send_byte(8'h0D);
    checks++; if (o_err_valid !== 1'b1 || o_err_code !== 2'd2) begin fails++; $display("FAIL len_short valid=%b code=%0d exp 1/2", o_err_valid, o_err_code); end
    checks++; if (o_cmd_valid !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL len_short_idle valid=%b busy=%b exp 0/0", o_cmd_valid, o_busy); end
    send_str("r 0004");
    send_byte("0");
    checks++; if (o_err_valid !== 1'b1 || o_err_code !== 2'd2 || o_busy !== 1'b1) begin fails++; $display("FAIL len_long valid=%b code=%0d busy=%b exp 1/2/1", o_err_valid, o_err_code, o_busy); end
    send_byte(8'h0D);
    checks++; if (o_cmd_valid !== 1'b0 || o_busy !== 1'b0 || err_seen !== e0 + 2) begin fails++; $display("FAIL len_long_end valid=%b busy=%b strobes=%0d exp 0/0/2", o_cmd_valid, o_busy, err_seen - e0); end
  endtask

  task automatic test_back_to_back();
    int e0 = err_seen;
    send_str("r 1234"); send_byte(8'h0D);
    send_byte("r");
    checks++; if (o_err_valid !== 1'b1 || o_err_code !== 2'd3) begin fails++; $display("FAIL ovr_strobe valid=%b code=%0d exp 1/3", o_err_valid, o_err_code); end
    checks++; if (o_cmd_valid !== 1'b1 || o_cmd_op !== 2'd1 || o_cmd_addr !== 16'h1234) begin fails++; $display("FAIL ovr_cmd_intact valid=%b op=%0d addr=%h exp 1/1/1234", o_cmd_valid, o_cmd_op, o_cmd_addr); end
    i_cmd_ready = 1'b1; send_byte("w"); i_cmd_ready = 1'b0;
    checks++; if (o_cmd_valid !== 1'b0 || o_busy !== 1'b0 || o_err_code !== 2'd3 || o_err_valid !== 1'b1) begin fails++; $display("FAIL ovr_hs valid=%b busy=%b err=%b code=%0d exp 0/0/1/3", o_cmd_valid, o_busy, o_err_valid, o_err_code); end
    send_str("r ABCD"); send_byte(8'h0D);
    checks++; if (o_cmd_valid !== 1'b1 || o_cmd_op !== 2'd1 || o_cmd_addr !== 16'hABCD || err_seen !== e0 + 2) begin fails++; $display("FAIL ovr_next valid=%b op=%0d addr=%h strobes=%0d exp 1/1/abcd/2", o_cmd_valid, o_cmd_op, o_cmd_addr, err_seen - e0); end
    i_cmd_ready = 1'b1; tick(); i_cmd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int e0;
    send_str("w 12");
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (o_cmd_valid !== 1'b0 || o_busy !== 1'b0 || o_err_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_ctl valid=%b busy=%b err=%b exp 0/0/0", o_cmd_valid, o_busy, o_err_valid); end
    checks++; if (o_cmd_addr !== 16'h0000 || o_cmd_op !== 2'd0 || o_cmd_wdata !== 32'd0) begin fails++; $display("FAIL rst_mid_fields addr=%h op=%0d wdata=%h exp 0", o_cmd_addr, o_cmd_op, o_cmd_wdata); end
    e0 = err_seen;
    send_str("br 00FF 10"); send_byte(8'h0D);
    checks++; if (o_cmd_valid !== 1'b1 || o_cmd_op !== 2'd2 || o_cmd_addr !== 16'h00FF || o_cmd_len !== 8'h10 || o_cmd_wdata !== 32'd0) begin fails++; $display("FAIL rst_mid_next valid=%b op=%0d addr=%h len=%h wdata=%h exp 1/2/00ff/10/0", o_cmd_valid, o_cmd_op, o_cmd_addr, o_cmd_len, o_cmd_wdata); end
    checks++; if (err_seen !== e0) begin fails++; $display("FAIL rst_mid_err strobes=%0d exp=0", err_seen - e0); end
    i_cmd_ready = 1'b1; tick(); i_cmd_ready = 1'b0;
    checks++; if (o_cmd_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_drop got=%b exp=0", o_cmd_valid); end
  endtask

  initial begin
    rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_cmd_ready = 1'b0;
    tick();
    test_reset();
    test_write();
    test_read_stall();
    test_burst();
    test_syntax();
    test_length();
    test_back_to_back();
    test_reset_mid();
    repeat (2) tick();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command parser between the UART receiver and the AXI master engine of the uart_axi controller. Consumes ASCII bytes from the UART RX strobe interface, recognises the `w`, `r` and `br` line commands, converts hex fields to binary, and presents one decoded command per line on a valid/ready interface to the AXI master. Malformed lines are reported on a one-cycle error strobe and discarded up to the next CR.

## Interface
- P_ADDR_W, 16, address width; exactly 4 hex digits are parsed.
- P_DATA_W, 32, write data width; exactly 8 hex digits are parsed.
- P_LEN_W, 8, burst length width; exactly 2 hex digits are parsed.
- aclk  in  1  clock; the single clock of the block.
- rst  in  1  reset; synchronous, active-high.
- i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a received byte. No backpressure.
- i_rx_data  in  8  received ASCII byte.
- o_cmd_valid  out  1  decoded command available.
- i_cmd_ready  in  1  AXI master accepts the command.
- o_cmd_op  out  2  cmd_op_t: CMD_WR=0, CMD_RD=1, CMD_RB=2.
- o_cmd_addr  out  P_ADDR_W  byte address.
- o_cmd_wdata  out  P_DATA_W  write data (CMD_WR only, else 0).
- o_cmd_len  out  P_LEN_W  AXI ARLEN encoding, beats = value+1 (CMD_RB only, else 0).
- o_err_valid  out  1  one-cycle error strobe.
- o_err_code  out  2  err_code_t: ERR_SYNTAX=1, ERR_LENGTH=2, ERR_OVERRUN=3; valid with o_err_valid.
- o_busy  out  1  high in any state other than S_IDLE.

## Operation
- Grammar, case-insensitive letters and hex: `w AAAA DDDDDDDD<CR>`, `r AAAA<CR>`, `br AAAA LL<CR>`. CR = 0x0D, separator is exactly one 0x20.
- States: S_IDLE, S_OPB (after `b`, expects `r`), S_SP1, S_ADDR, S_SP2, S_DATA, S_LEN, S_CR (rd: after 4 addr digits), S_ISSUE, S_FLUSH.
- S_IDLE: `w`->S_SP1 (op WR), `r`->S_SP1 (op RD), `b`->S_OPB; CR and LF (0x0A) ignored; any other byte -> ERR_SYNTAX, S_FLUSH.
- S_ADDR/S_DATA/S_LEN: hex digit shifts into field accumulator (acc <= {acc[W-5:0], nib}), digit counter increments. After the required count: WR -> S_SP2 then S_DATA; RD -> S_CR; RB -> S_SP2 then S_LEN; last field complete -> S_CR.
- S_CR: CR -> S_ISSUE; any other byte -> ERR_LENGTH (hex digit, too many digits) or ERR_SYNTAX, S_FLUSH.
- Non-hex, non-CR byte inside a field -> ERR_SYNTAX, S_FLUSH. CR before the field is complete -> ERR_LENGTH, S_IDLE directly (line already terminated).
- Wrong byte where a space is expected -> ERR_SYNTAX, S_FLUSH; CR there -> ERR_LENGTH, S_IDLE.
- S_FLUSH: discard bytes until CR, then S_IDLE.
- S_ISSUE: o_cmd_valid high; on i_cmd_ready -> S_IDLE, accumulators cleared. Byte arriving in S_ISSUE is dropped, ERR_OVERRUN strobed; the command is still issued.

## Timing
- Reset: all outputs 0, state S_IDLE, accumulators and digit counter 0. Reset mid-line or mid-issue discards the command; no error strobe.
- CR accepted at cycle t -> o_cmd_valid high at t+1. All cmd outputs registered and stable while o_cmd_valid high.
- Handshake: transfer on o_cmd_valid & i_cmd_ready; o_cmd_valid low at the following cycle. i_cmd_ready ignored when o_cmd_valid low.
- Byte in S_ISSUE on the handshake cycle: handshake completes, byte dropped, ERR_OVERRUN strobed.
- o_err_valid: registered, asserted the cycle after the offending byte, exactly one cycle.
- Throughput: one byte per cycle with no gaps.

## Structure
- Package uart_axi_pkg: cmd_op_t, err_code_t, ASCII constants CHR_CR, CHR_LF, CHR_SP, function hex2nib(byte) returning {valid, nibble[3:0]}.
- Single module, no sub-module; hex decode is the package function.

## Test plan
- `w 0FEC 1234ABCD<CR>` -> op=WR, addr=0x0FEC, wdata=0x1234ABCD, len=0; o_cmd_valid one cycle after CR byte.
- `r 0fec<CR>` with i_cmd_ready held low 20 cycles -> valid and fields (RD, 0x0FEC) stable 20 cycles, drop one cycle after ready.
- `br 0000 03<CR>` -> op=RB, addr=0x0000, len=0x03, wdata=0.
- `w 00g4 00000000<CR>` -> ERR_SYNTAX at `g`, no command; following `r 0004<CR>` decodes correctly.
- `r 004<CR>` -> ERR_LENGTH, no command, parser in S_IDLE; `r 00040<CR>` -> ERR_LENGTH at 5th digit, flush to CR.
- Back-to-back lines with ready low, byte `r` arriving during S_ISSUE -> ERR_OVERRUN, first command issued intact; rst asserted mid-field -> all outputs 0, next line parsed cleanly.
